sd_spi_cmd_engine: RTL and testbench
====================================

SD_SPI_CMD_ENGINE -- requirements
Module: sd_spi_cmd_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, giving CLOCK_50 cycles per SCLK half-period (>=2; default gives 200 kHz).
REQ-002 SHALL have parameter NCR_MAX, default 8, giving the number of response-poll bytes before timeout (1..255).
REQ-003 SHALL have parameter INIT_CLKS, default 80, giving the number of SCLK cycles in the init sequence (multiple of 8).
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port init_req, input, 1 bit: pulse that starts the power-up clock sequence.
REQ-007 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-008 SHALL have port cmd_ready, output, 1 bit: engine idle and able to accept.
REQ-009 SHALL have port cmd_index, input, 6 bits: SD command number.
REQ-010 SHALL have port cmd_arg, input, 32 bits: command argument.
REQ-011 SHALL have port cmd_long, input, 1 bit: 0 = R1 (8-bit) response, 1 = R3/R7 (40-bit) response.
REQ-012 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port resp_data, output, 40 bits: response, right-justified (R1 in [7:0]).
REQ-014 SHALL have port resp_timeout, output, 1 bit: qualifies resp_valid; 1 = no response received.
REQ-015 SHALL have port sd_cs_n, output, 1 bit: chip select (SD_DAT[3]).
REQ-016 SHALL have port sd_sclk, output, 1 bit: SPI clock (SD_CLK).
REQ-017 SHALL have port sd_mosi, output, 1 bit: SPI data out (SD_CMD).
REQ-018 SHALL have port sd_miso, input, 1 bit: SPI data in (SD_DAT[0]), already synchronised.

Function
REQ-019 SHALL run SPI mode 0: sd_sclk idles low, MISO is sampled on the rising edge, MOSI changes after the falling edge.
REQ-020 SHALL run the divider counter only outside IDLE; sd_sclk SHALL toggle when the counter reaches CLK_DIV-1, and the counter SHALL then wrap to 0.
REQ-021 SHALL use the FSM states IDLE, INIT, SEND, WAIT, RECV, TAIL.
REQ-022 IDLE: cmd_ready=1, sd_cs_n=1, sd_mosi=1; init_req SHALL go to INIT; otherwise cmd_valid SHALL go to SEND; init_req SHALL win if both are asserted.
REQ-023 SHALL latch cmd_index, cmd_arg and cmd_long on acceptance, and SHALL drop cmd_ready the next cycle.
REQ-024 INIT: SHALL output INIT_CLKS SCLK cycles with sd_cs_n=1 and sd_mosi=1, then return to IDLE with no resp_valid.
REQ-025 SEND: sd_cs_n=0; SHALL shift a 48-bit frame MSB first: 0, 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], 1.
REQ-026 SHALL compute CRC7 internally (poly x^7+x^3+1, init 0) over the first 40 frame bits.
REQ-027 WAIT: sd_mosi=1; SHALL sample MISO each rising edge; the first 0 sampled SHALL be bit 7 of the response, then go to RECV.
REQ-028 If NCR_MAX*8 bits are sampled with no 0, WAIT SHALL go to TAIL and flag a timeout.
REQ-029 RECV: SHALL capture the remaining 7 (cmd_long=0) or 39 (cmd_long=1) bits MSB first; unused upper resp_data bits SHALL be 0.
REQ-030 TAIL: SHALL issue 8 SCLK cycles with sd_mosi=1, then raise sd_cs_n and return to IDLE.
REQ-031 On return to IDLE from TAIL, SHALL pulse resp_valid for one cycle.
REQ-032 resp_data SHALL hold its value until the next resp_valid.
REQ-033 On timeout, resp_data SHALL be 40'hFF_FFFF_FFFF.
REQ-034 SHALL end every transaction with sd_sclk low.
REQ-035 SHALL ignore cmd_valid and init_req outside IDLE.

Reset
REQ-036 On reset, SHALL enter IDLE with cmd_ready=1, resp_valid=0, resp_timeout=0, resp_data=0, sd_cs_n=1, sd_sclk=0, sd_mosi=1, counters and CRC cleared.
REQ-037 Reset mid-transaction SHALL abort on the next edge with no resp_valid pulse.

Verification
REQ-038 init_req after reset -> exactly 80 SCLK pulses, sd_cs_n=1 throughout, MOSI=1, cmd_ready low during the sequence then high.
REQ-039 CMD0, arg 0, cmd_long=0, MISO responds 0x01 after 2 poll bytes -> MOSI frame 0x400000000095, resp_data=0x01, resp_timeout=0.
REQ-040 CMD8, arg 0x1AA, cmd_long=1, card returns 0x01_000001AA -> frame 0x48000001AA87, resp_data=0x01000001AA.
REQ-041 CMD0 with MISO held 1 -> after NCR_MAX*8 poll bits plus 8 tail clocks: resp_valid=1, resp_timeout=1, resp_data all 1s.
REQ-042 Reset asserted during the SEND arg bits -> next cycle sd_cs_n=1, sd_sclk=0, no resp_valid; a following CMD0 completes normally.
REQ-043 init_req and cmd_valid asserted in the same cycle -> INIT runs, command not accepted; cmd_valid held -> command accepted after INIT.

Source files
------------

// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine: issues SD commands over SPI (mode 0) and collects the response.
//   CLOCK_50     : sole clock, rising edge
//   reset        : synchronous, active-high
//   init_req     : pulse, starts the INIT_CLKS power-up clock burst (CS high, MOSI high)
//   cmd_valid/cmd_ready, cmd_index, cmd_arg, cmd_long : command request handshake
//   resp_valid   : one-cycle completion pulse; resp_data/resp_timeout valid with it
//   sd_cs_n, sd_sclk, sd_mosi : SPI outputs to the card
//   sd_miso      : SPI input from the card, already synchronised
module sd_spi_cmd_engine #(
  parameter int unsigned CLK_DIV   = 125,
  parameter int unsigned NCR_MAX   = 8,
  parameter int unsigned INIT_CLKS = 80
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        init_req,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_long,
  output logic        resp_valid,
  output logic [39:0] resp_data,
  output logic        resp_timeout,
  output logic        sd_cs_n,
  output logic        sd_sclk,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned FRAME_W  = 48;
  localparam int unsigned RESP_W   = 40;
  localparam int unsigned CRC_SPAN = 40;
  localparam int unsigned TAIL_CLKS = 8;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CLKS - 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(NCR_MAX * 8 - 1);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_SPAN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    RECV = 3'd4,
    TAIL = 3'd5
  } state_t;

  state_t state, state_n;

  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   recv_last;
  logic [FRAME_W-1:0] sr;
  logic [6:0]         crc;
  logic [6:0]         crc_nx;
  logic               crc_fb;
  logic [RESP_W-1:0]  rx;
  logic               long_q;
  logic               to_q;

  logic tick, rise, fall, count_en;
  logic ready_d, cs_n_d, mosi_d, valid_d;

  // SCLK half-period tick; rise/fall name the SCLK edge the tick produces
  assign tick = (state != IDLE) && (div_cnt == DIV_LAST);
  assign rise = tick && !sd_sclk;
  assign fall = tick && sd_sclk;

  // Bits still to capture after the leading 0 found during polling
  assign recv_last = long_q ? CNT_W'(RESP_W - 2) : CNT_W'(6);

  // Serial CRC7 (x^7 + x^3 + 1) over the bit currently on the wire
  assign crc_fb = crc[6] ^ sr[FRAME_W-1];
  assign crc_nx = {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);

  // Per-state bit counter event: falling edges while driving, rising edges while sampling
  always_comb begin
    count_en = 1'b0;
    unique case (state)
      INIT, SEND:       count_en = fall;
      WAIT, RECV, TAIL: count_en = rise;
      default:          count_en = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (init_req)       state_n = INIT;
        else if (cmd_valid) state_n = SEND;
      end
      INIT: if (fall && bit_cnt == INIT_LAST) state_n = IDLE;
      SEND: if (fall && bit_cnt == SEND_LAST) state_n = WAIT;
      WAIT: begin
        if (rise) begin
          if (!sd_miso)                  state_n = RECV;
          else if (bit_cnt == POLL_LAST) state_n = TAIL;
        end
      end
      RECV: if (rise && bit_cnt == recv_last) state_n = TAIL;
      // TAIL is entered with SCLK high; count 8 more rising edges, leave on the following fall
      TAIL: if (fall && bit_cnt == CNT_W'(TAIL_CLKS)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic: next values of the registered SPI/handshake outputs
  always_comb begin
    ready_d = (state_n == IDLE);
    cs_n_d  = (state_n == IDLE) || (state_n == INIT);
    valid_d = (state == TAIL) && (state_n == IDLE);
    mosi_d  = 1'b1;
    if (state_n == SEND) begin
      if (state != SEND)
        mosi_d = 1'b0;  // start bit is presented before the first rising edge
      else if (fall)
        mosi_d = (bit_cnt == CRC_LAST) ? crc_nx[6] : sr[FRAME_W-2];
      else
        mosi_d = sd_mosi;
    end
  end

  // Registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cmd_ready  <= 1'b1;
      sd_cs_n    <= 1'b1;
      sd_mosi    <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      cmd_ready  <= ready_d;
      sd_cs_n    <= cs_n_d;
      sd_mosi    <= mosi_d;
      resp_valid <= valid_d;
    end
  end

  // Datapath: divider, SCLK, counters, frame shifter, CRC, response capture
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_cnt      <= '0;
      sd_sclk      <= 1'b0;
      bit_cnt      <= '0;
      sr           <= '0;
      crc          <= '0;
      long_q       <= 1'b0;
      to_q         <= 1'b0;
      rx           <= '0;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
    end else begin
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DIV_W'(1);

      if (tick) sd_sclk <= ~sd_sclk;

      if (state != state_n) bit_cnt <= '0;
      else if (count_en)    bit_cnt <= bit_cnt + CNT_W'(1);

      // Accept: low byte is filler, replaced by {crc, stop} after 40 bits
      if (state == IDLE && state_n == SEND) begin
        sr     <= {2'b01, cmd_index, cmd_arg, 8'hFF};
        crc    <= '0;
        long_q <= cmd_long;
        to_q   <= 1'b0;
      end

      if (state == SEND && fall) begin
        if (bit_cnt <= CRC_LAST) crc <= crc_nx;
        if (bit_cnt == CRC_LAST) sr <= {crc_nx, 1'b1, 40'h0};
        else                     sr <= {sr[FRAME_W-2:0], 1'b1};
      end

      if (state == WAIT && rise) begin
        if (!sd_miso)                  rx   <= '0;  // leading 0 is response bit 7
        else if (bit_cnt == POLL_LAST) to_q <= 1'b1;
      end

      if (state == RECV && rise) rx <= {rx[RESP_W-2:0], sd_miso};

      if (valid_d) begin
        resp_data    <= to_q ? '1 : rx;
        resp_timeout <= to_q;
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Directed bench for sd_spi_cmd_engine with a small SD card model on the SPI pins.
module tb_sd_spi_cmd_engine;

  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned NCR_MAX   = 8;
  localparam int unsigned INIT_CLKS = 80;
  localparam int          BUDGET    = 3000;

  logic        CLOCK_50  = 1'b0;
  logic        reset     = 1'b1;
  logic        init_req  = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg   = '0;
  logic        cmd_long  = 1'b0;
  logic        cmd_ready;
  logic        resp_valid;
  logic [39:0] resp_data;
  logic        resp_timeout;
  logic        sd_cs_n;
  logic        sd_sclk;
  logic        sd_mosi;
  logic        sd_miso = 1'b1;

  int checks = 0;
  int errors = 0;

  sd_spi_cmd_engine #(
    .CLK_DIV  (CLK_DIV),
    .NCR_MAX  (NCR_MAX),
    .INIT_CLKS(INIT_CLKS)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .init_req    (init_req),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .cmd_long    (cmd_long),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_timeout(resp_timeout),
    .sd_cs_n     (sd_cs_n),
    .sd_sclk     (sd_sclk),
    .sd_mosi     (sd_mosi),
    .sd_miso     (sd_miso)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Bus monitor: SCLK pulse counts, MOSI frame capture, CS activity
  int          total_rises = 0;
  int          mosi0_rises = 0;
  int          cs_falls    = 0;
  int          txn_rises   = 0;
  logic [47:0] frame       = '0;

  always @(posedge sd_sclk or negedge sd_cs_n) begin
    if (sd_sclk) begin
      total_rises++;
      if (sd_mosi == 1'b0) mosi0_rises++;
      if (!sd_cs_n) begin
        if (txn_rises < 48) frame = {frame[46:0], sd_mosi};
        txn_rises++;
      end
    end else begin
      cs_falls++;
      txn_rises = 0;
    end
  end

  // Card model: after the 48 command bits, card_delay poll bits of 1, then card_len response bits
  int          card_delay = 0;
  int          card_len   = 0;
  logic [39:0] card_resp  = '0;

  always @(negedge sd_sclk) begin
    int k;
    k = txn_rises - 48;
    if (k < card_delay || (k - card_delay) >= card_len)
      sd_miso = 1'b1;
    else
      sd_miso = card_resp[card_len - 1 - (k - card_delay)];
  end

  // Completion monitor
  int          valid_cycles = 0;
  logic [39:0] last_data    = '0;
  logic        last_to      = 1'b0;

  always @(posedge CLOCK_50) begin
    #1;
    if (resp_valid === 1'b1) begin
      valid_cycles++;
      last_data = resp_data;
      last_to   = resp_timeout;
    end
  end

  task automatic set_card(input int delay, input int len, input logic [39:0] resp);
    card_delay = delay;
    card_len   = len;
    card_resp  = resp;
  endtask

  // Called at a falling clock edge; the command is accepted on the next rising edge
  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic lng);
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_long  = lng;
    cmd_valid = 1'b1;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int start, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge CLOCK_50);
      if (valid_cycles != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_timeout !== 1'b0) begin errors++; $display("FAIL reset_resp_timeout: got %b expected 0", resp_timeout); end
    checks++; if (resp_data !== 40'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0000000000", resp_data); end
    checks++; if (sd_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", sd_cs_n); end
    checks++; if (sd_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sd_sclk); end
    checks++; if (sd_mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b expected 1", sd_mosi); end
  endtask

  task automatic test_init();
    int s_r, s_m, s_c, s_v;
    bit ok;
    s_r = total_rises; s_m = mosi0_rises; s_c = cs_falls; s_v = valid_cycles;
    init_req = 1'b1;
    @(negedge CLOCK_50);
    init_req = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL init_ready_low: got %b expected 0", cmd_ready); end
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge CLOCK_50);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL init_done: got timeout expected cmd_ready=1"); end
    checks++; if (total_rises - s_r != 80) begin errors++; $display("FAIL init_pulses: got %0d expected 80", total_rises - s_r); end
    checks++; if (mosi0_rises != s_m) begin errors++; $display("FAIL init_mosi: got %0d zero bits expected 0", mosi0_rises - s_m); end
    checks++; if (cs_falls != s_c) begin errors++; $display("FAIL init_cs: got %0d cs falls expected 0", cs_falls - s_c); end
    repeat (4) @(negedge CLOCK_50);
    checks++; if (valid_cycles != s_v) begin errors++; $display("FAIL init_no_valid: got %0d pulses expected 0", valid_cycles - s_v); end
    checks++; if (sd_sclk !== 1'b0) begin errors++; $display("FAIL init_sclk_idle: got %b expected 0", sd_sclk); end
  endtask

  task automatic test_cmd0();
    int s_r, s_v;
    bit ok;
    set_card(16, 8, 40'h01);
    s_r = total_rises; s_v = valid_cycles;
    issue(6'd0, 32'h0, 1'b0);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd0_ready_drop: got %b expected 0", cmd_ready); end
    wait_valid(s_v, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cmd0_done: got timeout expected resp_valid"); end
    checks++; if (sd_cs_n !== 1'b1) begin errors++; $display("FAIL cmd0_cs_end: got %b expected 1", sd_cs_n); end
    checks++; if (sd_sclk !== 1'b0) begin errors++; $display("FAIL cmd0_sclk_end: got %b expected 0", sd_sclk); end
    checks++; if (frame !== 48'h400000000095) begin errors++; $display("FAIL cmd0_frame: got %h expected 400000000095", frame); end
    checks++; if (last_data !== 40'h01) begin errors++; $display("FAIL cmd0_data: got %h expected 0000000001", last_data); end
    checks++; if (last_to !== 1'b0) begin errors++; $display("FAIL cmd0_timeout: got %b expected 0", last_to); end
    checks++; if (total_rises - s_r != 80) begin errors++; $display("FAIL cmd0_pulses: got %0d expected 80", total_rises - s_r); end
    repeat (4) @(negedge CLOCK_50);
    checks++; if (valid_cycles - s_v != 1) begin errors++; $display("FAIL cmd0_pulse_width: got %0d cycles expected 1", valid_cycles - s_v); end
    checks++; if (resp_data !== 40'h01) begin errors++; $display("FAIL cmd0_data_hold: got %h expected 0000000001", resp_data); end
  endtask

  task automatic test_cmd8();
    int s_r, s_v;
    bit ok;
    set_card(8, 40, 40'h01000001AA);
    s_r = total_rises; s_v = valid_cycles;
    issue(6'd8, 32'h0000_01AA, 1'b1);
    wait_valid(s_v, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cmd8_done: got timeout expected resp_valid"); end
    checks++; if (frame !== 48'h48000001AA87) begin errors++; $display("FAIL cmd8_frame: got %h expected 48000001AA87", frame); end
    checks++; if (last_data !== 40'h01000001AA) begin errors++; $display("FAIL cmd8_data: got %h expected 01000001aa", last_data); end
    checks++; if (last_to !== 1'b0) begin errors++; $display("FAIL cmd8_timeout: got %b expected 0", last_to); end
    checks++; if (total_rises - s_r != 104) begin errors++; $display("FAIL cmd8_pulses: got %0d expected 104", total_rises - s_r); end
  endtask

  task automatic test_timeout();
    int s_r, s_v;
    bit ok;
    set_card(0, 0, 40'h0);
    s_r = total_rises; s_v = valid_cycles;
    issue(6'd0, 32'h0, 1'b0);
    wait_valid(s_v, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_done: got timeout expected resp_valid"); end
    checks++; if (last_to !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", last_to); end
    checks++; if (last_data !== 40'hFF_FFFF_FFFF) begin errors++; $display("FAIL to_data: got %h expected ffffffffff", last_data); end
    checks++; if (total_rises - s_r != 120) begin errors++; $display("FAIL to_pulses: got %0d expected 120", total_rises - s_r); end
    checks++; if (sd_sclk !== 1'b0) begin errors++; $display("FAIL to_sclk_end: got %b expected 0", sd_sclk); end
  endtask

  task automatic test_reset_mid();
    int s_v;
    bit ok;
    set_card(16, 8, 40'h01);
    s_v = valid_cycles;
    issue(6'd8, 32'h0000_01AA, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge CLOCK_50);
      if (txn_rises >= 20) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_reach_arg: got timeout expected 20 sclk rises"); end
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    checks++; if (sd_cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs: got %b expected 1", sd_cs_n); end
    checks++; if (sd_sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk: got %b expected 0", sd_sclk); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", cmd_ready); end
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    checks++; if (valid_cycles != s_v) begin errors++; $display("FAIL mid_no_valid: got %0d pulses expected 0", valid_cycles - s_v); end
    issue(6'd0, 32'h0, 1'b0);
    wait_valid(s_v, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_next_done: got timeout expected resp_valid"); end
    checks++; if (frame !== 48'h400000000095) begin errors++; $display("FAIL mid_next_frame: got %h expected 400000000095", frame); end
    checks++; if (last_data !== 40'h01 || last_to !== 1'b0) begin errors++; $display("FAIL mid_next_resp: got %h/%b expected 0000000001/0", last_data, last_to); end
  endtask

  task automatic test_init_and_cmd();
    int s_r, s_c, s_v;
    bit ok;
    set_card(16, 8, 40'h01);
    s_r = total_rises; s_c = cs_falls; s_v = valid_cycles;
    cmd_index = 6'd0; cmd_arg = 32'h0; cmd_long = 1'b0;
    init_req  = 1'b1;
    cmd_valid = 1'b1;
    @(negedge CLOCK_50);
    init_req = 1'b0;
    checks++; if (cmd_ready !== 1'b0 || sd_cs_n !== 1'b1) begin errors++; $display("FAIL both_init_wins: got ready=%b cs_n=%b expected 0/1", cmd_ready, sd_cs_n); end
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge CLOCK_50);
      if (cs_falls != s_c) begin ok = 1'b1; break; end
    end
    cmd_valid = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL both_accept: got timeout expected cs_n low"); end
    checks++; if (total_rises - s_r != 80) begin errors++; $display("FAIL both_init_first: got %0d pulses expected 80", total_rises - s_r); end
    wait_valid(s_v, ok);
    checks++; if (!ok) begin errors++; $display("FAIL both_done: got timeout expected resp_valid"); end
    checks++; if (frame !== 48'h400000000095) begin errors++; $display("FAIL both_frame: got %h expected 400000000095", frame); end
    checks++; if (last_data !== 40'h01 || last_to !== 1'b0) begin errors++; $display("FAIL both_resp: got %h/%b expected 0000000001/0", last_data, last_to); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_cmd0();
    test_cmd8();
    test_timeout();
    test_reset_mid();
    test_init_and_cmd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
